alu_reservation_station: RTL and testbench

//  Age-ordered reservation station between the decode/control stage and the integer ALU/shift/mult/div

---
 rtl/alu_reservation_station.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
//==============================================================================
// Module : alu_reservation_station
// Brief  : Age-ordered, collapsing reservation station for ALU-class ops with
//          CDB wakeup, oldest-ready select and a registered valid/ready issue
//          port. Optional RS_PERF_CNT_EN adds stall/issue counters.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module alu_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,

    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [2:0]                 disp_aluop_i,
    input  logic [1:0]                 disp_whichmath_i,
    input  logic                       disp_leftshift_i,
    input  logic                       disp_savecond_i,
    input  logic [TAG_W-1:0]           disp_dest_tag_i,
    input  logic                       disp_src1_rdy_i,
    input  logic [TAG_W-1:0]           disp_src1_tag_i,
    input  logic [DATA_W-1:0]          disp_src1_val_i,
    input  logic                       disp_src2_rdy_i,
    input  logic [TAG_W-1:0]           disp_src2_tag_i,
    input  logic [DATA_W-1:0]          disp_src2_val_i,

    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [DATA_W-1:0]          cdb_val_i,

    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [2:0]                 issue_aluop_o,
    output logic [1:0]                 issue_whichmath_o,
    output logic                       issue_leftshift_o,
    output logic                       issue_savecond_o,
    output logic [TAG_W-1:0]           issue_dest_tag_o,
    output logic [DATA_W-1:0]          issue_op1_o,
    output logic [DATA_W-1:0]          issue_op2_o,

    output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef RS_PERF_CNT_EN
    ,
    output logic [15:0]                stall_full_cnt_o,
    output logic [15:0]                issue_cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [2:0]        aluop;
        logic [1:0]        whichmath;
        logic              leftshift;
        logic              savecond;
        logic [TAG_W-1:0]  dest;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
    } entry_t;

    entry_t             r_ent [DEPTH];
    entry_t             w_up  [DEPTH];
    entry_t             w_nxt [DEPTH];
    entry_t             w_new;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_app_idx;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_out_load;
    logic               w_remove;
    logic               w_disp_fire;

    logic               r_iss_valid;
    logic [2:0]         r_iss_aluop;
    logic [1:0]         r_iss_whichmath;
    logic               r_iss_leftshift;
    logic               r_iss_savecond;
    logic [TAG_W-1:0]   r_iss_dest;
    logic [DATA_W-1:0]  r_iss_op1;
    logic [DATA_W-1:0]  r_iss_op2;

    // Captures a broadcast result into any matching, still-waiting source.
    function automatic entry_t f_wake(input entry_t e, input logic cv,
                                      input logic [TAG_W-1:0] tag,
                                      input logic [DATA_W-1:0] val);
        entry_t r;
        r = e;
        if (cv && e.valid && !e.s1_rdy && (e.s1_tag == tag)) begin
            r.s1_rdy = 1'b1;
            r.s1_val = val;
        end
        if (cv && e.valid && !e.s2_rdy && (e.s2_tag == tag)) begin
            r.s2_rdy = 1'b1;
            r.s2_val = val;
        end
        return r;
    endfunction

    assign disp_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_disp_fire  = disp_valid_i & disp_ready_o & ~flush_i;
    assign w_out_load   = ~r_iss_valid | issue_ready_i;
    assign w_remove     = w_out_load & w_sel_found & ~flush_i;
    assign w_app_idx    = w_remove ? (r_count - CNT_W'(1)) : r_count;

    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_ent[i].valid && r_ent[i].s1_rdy && r_ent[i].s2_rdy) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        entry_t e;
        e.valid     = 1'b1;
        e.aluop     = disp_aluop_i;
        e.whichmath = disp_whichmath_i;
        e.leftshift = disp_leftshift_i;
        e.savecond  = disp_savecond_i;
        e.dest      = disp_dest_tag_i;
        e.s1_rdy    = disp_src1_rdy_i;
        e.s1_tag    = disp_src1_tag_i;
        e.s1_val    = disp_src1_val_i;
        e.s2_rdy    = disp_src2_rdy_i;
        e.s2_tag    = disp_src2_tag_i;
        e.s2_val    = disp_src2_val_i;
        w_new       = f_wake(e, cdb_valid_i, cdb_tag_i, cdb_val_i);
    end

    // Compaction first (entries above the issued slot move down), then wakeup,
    // then the new op lands at the first free slot of the compacted queue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_up[i] = '0;
        for (int i = 0; i < DEPTH-1; i++) w_up[i] = r_ent[i+1];
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_remove && (i >= int'(w_sel_idx))) ? w_up[i] : r_ent[i];
            w_nxt[i] = f_wake(w_nxt[i], cdb_valid_i, cdb_tag_i, cdb_val_i);
            if (w_disp_fire && (i == int'(w_app_idx))) w_nxt[i] = w_new;
            if (flush_i) w_nxt[i] = '0;
        end
    end

    always_comb begin
        w_count_nxt = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_remove);
        if (flush_i) w_count_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid     <= 1'b0;
            r_iss_aluop     <= '0;
            r_iss_whichmath <= '0;
            r_iss_leftshift <= 1'b0;
            r_iss_savecond  <= 1'b0;
            r_iss_dest      <= '0;
            r_iss_op1       <= '0;
            r_iss_op2       <= '0;
        end else if (flush_i) begin
            r_iss_valid <= 1'b0;
        end else if (w_out_load) begin
            r_iss_valid <= w_sel_found;
            if (w_sel_found) begin
                r_iss_aluop     <= r_ent[w_sel_idx].aluop;
                r_iss_whichmath <= r_ent[w_sel_idx].whichmath;
                r_iss_leftshift <= r_ent[w_sel_idx].leftshift;
                r_iss_savecond  <= r_ent[w_sel_idx].savecond;
                r_iss_dest      <= r_ent[w_sel_idx].dest;
                r_iss_op1       <= r_ent[w_sel_idx].s1_val;
                r_iss_op2       <= r_ent[w_sel_idx].s2_val;
            end
        end
    end

    assign issue_valid_o     = r_iss_valid;
    assign issue_aluop_o     = r_iss_aluop;
    assign issue_whichmath_o = r_iss_whichmath;
    assign issue_leftshift_o = r_iss_leftshift;
    assign issue_savecond_o  = r_iss_savecond;
    assign issue_dest_tag_o  = r_iss_dest;
    assign issue_op1_o       = r_iss_op1;
    assign issue_op2_o       = r_iss_op2;
    assign count_o           = r_count;

`ifdef RS_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_issue_cnt;

    // Saturating counters; deliberately survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (disp_valid_i && !disp_ready_o && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (r_iss_valid && issue_ready_i && (r_issue_cnt != 16'hFFFF))
                r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign stall_full_cnt_o = r_stall_cnt;
    assign issue_cnt_o      = r_issue_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
//==============================================================================
// Module : tb_alu_reservation_station
// Brief  : Directed bench with a queue-based reference model compared every cycle.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_alu_reservation_station;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              dv = 1'b0;
    logic              d_rdy;
    logic [2:0]        d_aluop = '0;
    logic [1:0]        d_wm = '0;
    logic              d_ls = 1'b0;
    logic              d_sc = 1'b0;
    logic [TAG_W-1:0]  d_dest = '0;
    logic              d_r1 = 1'b0, d_r2 = 1'b0;
    logic [TAG_W-1:0]  d_t1 = '0, d_t2 = '0;
    logic [DATA_W-1:0] d_v1 = '0, d_v2 = '0;
    logic              cv = 1'b0;
    logic [TAG_W-1:0]  ctag = '0;
    logic [DATA_W-1:0] cval = '0;
    logic              iss_ready = 1'b1;

    logic              iss_valid;
    logic [2:0]        iss_aluop;
    logic [1:0]        iss_wm;
    logic              iss_ls, iss_sc;
    logic [TAG_W-1:0]  iss_dest;
    logic [DATA_W-1:0] iss_op1, iss_op2;
    logic [2:0]        cnt;
`ifdef RS_PERF_CNT_EN
    logic [15:0]       stall_cnt, issue_cnt;
`endif

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .disp_valid_i(dv), .disp_ready_o(d_rdy),
        .disp_aluop_i(d_aluop), .disp_whichmath_i(d_wm),
        .disp_leftshift_i(d_ls), .disp_savecond_i(d_sc), .disp_dest_tag_i(d_dest),
        .disp_src1_rdy_i(d_r1), .disp_src1_tag_i(d_t1), .disp_src1_val_i(d_v1),
        .disp_src2_rdy_i(d_r2), .disp_src2_tag_i(d_t2), .disp_src2_val_i(d_v2),
        .cdb_valid_i(cv), .cdb_tag_i(ctag), .cdb_val_i(cval),
        .issue_valid_o(iss_valid), .issue_ready_i(iss_ready),
        .issue_aluop_o(iss_aluop), .issue_whichmath_o(iss_wm),
        .issue_leftshift_o(iss_ls), .issue_savecond_o(iss_sc),
        .issue_dest_tag_o(iss_dest), .issue_op1_o(iss_op1), .issue_op2_o(iss_op2),
        .count_o(cnt)
`ifdef RS_PERF_CNT_EN
        , .stall_full_cnt_o(stall_cnt), .issue_cnt_o(issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an age-ordered queue ----------------
    typedef struct packed {
        logic [2:0]        aluop;
        logic [1:0]        wm;
        logic              ls, sc;
        logic [TAG_W-1:0]  dest;
        logic              r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        logic              r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
    } m_ent_t;

    m_ent_t      m_q[$];
    m_ent_t      m_iss;
    m_ent_t      m_new;
    bit          m_iss_v = 1'b0;
    int          m_sel;
    bit          m_acc, m_stall_now, m_hs;
    logic [15:0] m_stall = '0;
    logic [15:0] m_icnt = '0;

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r = e;
        if (cv && !e.r1 && e.t1 == ctag) begin r.r1 = 1'b1; r.v1 = cval; end
        if (cv && !e.r2 && e.t2 == ctag) begin r.r2 = 1'b1; r.v2 = cval; end
        return r;
    endfunction

    always @(negedge rst_n) begin
        m_q.delete();
        m_iss_v = 1'b0;
        m_stall = '0;
        m_icnt  = '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            m_acc       = dv && (m_q.size() < DEPTH);
            m_stall_now = dv && (m_q.size() >= DEPTH);
            m_hs        = m_iss_v && iss_ready;
            if (m_stall_now && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (m_hs && m_icnt != 16'hFFFF) m_icnt = m_icnt + 16'd1;
            if (flush) begin
                m_q.delete();
                m_iss_v = 1'b0;
            end else begin
                if (!m_iss_v || iss_ready) begin
                    m_sel = -1;
                    for (int k = 0; k < m_q.size(); k++)
                        if (m_sel < 0 && m_q[k].r1 && m_q[k].r2) m_sel = k;
                    if (m_sel >= 0) begin
                        m_iss   = m_q[m_sel];
                        m_iss_v = 1'b1;
                        m_q.delete(m_sel);
                    end else begin
                        m_iss_v = 1'b0;
                    end
                end
                for (int k = 0; k < m_q.size(); k++) m_q[k] = wake(m_q[k]);
                if (m_acc) begin
                    m_new = '{aluop: d_aluop, wm: d_wm, ls: d_ls, sc: d_sc, dest: d_dest,
                              r1: d_r1, t1: d_t1, v1: d_v1, r2: d_r2, t2: d_t2, v2: d_v2};
                    m_q.push_back(wake(m_new));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("disp_ready", {63'd0, d_rdy}, {63'd0, m_q.size() < DEPTH});
            chk("count", {61'd0, cnt}, 64'(m_q.size()));
            chk("issue_valid", {63'd0, iss_valid}, {63'd0, m_iss_v});
            if (m_iss_v) begin
                chk("issue_aluop", {61'd0, iss_aluop}, {61'd0, m_iss.aluop});
                chk("issue_whichmath", {62'd0, iss_wm}, {62'd0, m_iss.wm});
                chk("issue_ls_sc", {62'd0, iss_ls, iss_sc}, {62'd0, m_iss.ls, m_iss.sc});
                chk("issue_dest", {59'd0, iss_dest}, {59'd0, m_iss.dest});
                chk("issue_op1", iss_op1, m_iss.v1);
                chk("issue_op2", iss_op2, m_iss.v2);
            end
`ifdef RS_PERF_CNT_EN
            chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, m_stall});
            chk("issue_cnt", {48'd0, issue_cnt}, {48'd0, m_icnt});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_disp(input logic [2:0] op, input logic [1:0] wm, input logic [4:0] dest,
                            input logic r1, input logic [4:0] t1, input logic [63:0] v1,
                            input logic r2, input logic [4:0] t2, input logic [63:0] v2);
        dv = 1'b1; d_aluop = op; d_wm = wm; d_ls = (wm == 2'd1); d_sc = op[0];
        d_dest = dest; d_r1 = r1; d_t1 = t1; d_v1 = v1; d_r2 = r2; d_t2 = t2; d_v2 = v2;
    endtask

    task automatic set_cdb(input logic [4:0] t, input logic [63:0] v);
        cv = 1'b1; ctag = t; cval = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dv = 1'b0; cv = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_disp_ready", {63'd0, d_rdy}, 64'd1);
        chk("rst_count", {61'd0, cnt}, 64'd0);
        chk("rst_issue_valid", {63'd0, iss_valid}, 64'd0);
        chk("rst_issue_op1", iss_op1, 64'd0);

        // 1: ADD with both sources ready
        iss_ready = 1'b1;
        set_disp(3'd2, 2'd0, 5'd1, 1'b1, 5'd0, 64'd5, 1'b1, 5'd0, 64'd7);
        tick();
        chk("t1_not_yet", {63'd0, iss_valid}, 64'd0);
        tick();
        chk("t1_valid", {63'd0, iss_valid}, 64'd1);
        chk("t1_op1", iss_op1, 64'd5);
        chk("t1_op2", iss_op2, 64'd7);
        chk("t1_aluop", {61'd0, iss_aluop}, 64'd2);
        tick();

        // 2: src1 waits on tag 3
        set_disp(3'd1, 2'd0, 5'd2, 1'b0, 5'd3, 64'd0, 1'b1, 5'd0, 64'd1);
        tick();
        tick();
        set_cdb(5'd3, 64'h99);
        tick();
        chk("t2_wait", {63'd0, iss_valid}, 64'd0);
        tick();
        chk("t2_valid", {63'd0, iss_valid}, 64'd1);
        chk("t2_op1", iss_op1, 64'h99);
        tick();

        // 3: fill with unready ops, then attempt one more
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd3, 2'd2, 5'(16 + k), 1'b0, 5'(10 + k), 64'd0, 1'b1, 5'd0, 64'(k));
            tick();
        end
        chk("t3_full_ready", {63'd0, d_rdy}, 64'd0);
        chk("t3_full_count", {61'd0, cnt}, 64'd4);
        set_disp(3'd4, 2'd3, 5'd30, 1'b1, 5'd0, 64'd1, 1'b1, 5'd0, 64'd2);
        tick();
        chk("t3_held_count", {61'd0, cnt}, 64'd4);
        for (int k = 0; k < 4; k++) begin
            set_cdb(5'(10 + k), 64'(100 + k));
            tick();
        end
        repeat (3) tick();
        chk("t3_drained", {61'd0, cnt}, 64'd0);

        // 4: entry 1 ready, entries 0 and 2 share producer tag 20
        set_disp(3'd0, 2'd0, 5'h10, 1'b0, 5'd20, 64'd0, 1'b1, 5'd0, 64'hA);
        tick();
        set_disp(3'd0, 2'd0, 5'h11, 1'b1, 5'd0, 64'hB, 1'b1, 5'd0, 64'hB);
        tick();
        set_disp(3'd0, 2'd0, 5'h12, 1'b0, 5'd20, 64'd0, 1'b1, 5'd0, 64'hC);
        tick();
        chk("t4_first", {59'd0, iss_dest}, 64'h11);
        set_cdb(5'd20, 64'h2020);
        tick();
        chk("t4_gap", {63'd0, iss_valid}, 64'd0);
        tick();
        chk("t4_second", {59'd0, iss_dest}, 64'h10);
        tick();
        chk("t4_third", {59'd0, iss_dest}, 64'h12);
        chk("t4_third_op1", iss_op1, 64'h2020);
        tick();

        // 5: dispatch coincides with producer broadcast
        set_disp(3'd5, 2'd1, 5'd4, 1'b0, 5'd7, 64'd0, 1'b1, 5'd0, 64'd3);
        set_cdb(5'd7, 64'h1234);
        tick();
        tick();
        chk("t5_valid", {63'd0, iss_valid}, 64'd1);
        chk("t5_op1", iss_op1, 64'h1234);
        repeat (2) tick();

        // 6: stall, flush, then async reset mid-run
        iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(3'd6, 2'd0, 5'(k), 1'b1, 5'd0, 64'(8'hA1 + k), 1'b1, 5'd0, 64'd9);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_stall_op1", iss_op1, 64'hA1);
            chk("t6_stall_count", {61'd0, cnt}, 64'd3);
        end
        flush = 1'b1;
        set_disp(3'd7, 2'd0, 5'd9, 1'b1, 5'd0, 64'd1, 1'b1, 5'd0, 64'd1);
        tick();
        chk("t6_flush_valid", {63'd0, iss_valid}, 64'd0);
        chk("t6_flush_count", {61'd0, cnt}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            set_disp(3'd2, 2'd0, 5'(k), 1'b1, 5'd0, 64'(8'hE0 + k), 1'b1, 5'd0, 64'd2);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'd0, iss_valid}, 64'd0);
        chk("t6_rst_count", {61'd0, cnt}, 64'd0);
        chk("t6_rst_op1", iss_op1, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_rst_ready", {63'd0, d_rdy}, 64'd1);
        iss_ready = 1'b1;
        set_disp(3'd2, 2'd0, 5'd5, 1'b1, 5'd0, 64'h55, 1'b1, 5'd0, 64'h66);
        tick();
        tick();
        chk("t6_after_rst_op1", iss_op1, 64'h55);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
